// File: rtl/series_engine_if.sv
// ----------------------------------------------------------------------------
// series_engine_if: start/operand/result handshake plus coefficient ROM port. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface series_engine_if #(
    parameter int WIDTH   = 16,
    parameter int N_TERMS = 8
);
    localparam int CW = $clog2(N_TERMS);

    logic                    start;
    logic signed [WIDTH-1:0] x_in;
    logic                    alt_sign;
    logic [CW-1:0]           coef_addr;
    logic signed [WIDTH-1:0] coef_data;
    logic                    busy;
    logic                    done;
    logic signed [WIDTH-1:0] result;
    logic [CW:0]             terms_used;

    // master: requester plus ROM side; slave: the engine
    modport master (
        output start, x_in, alt_sign, coef_data,
        input  coef_addr, busy, done, result, terms_used
    );
    modport slave (
        input  start, x_in, alt_sign, coef_data,
        output coef_addr, busy, done, result, terms_used
    );
endinterface

`default_nettype wire

// File: rtl/series_engine.sv
// ----------------------------------------------------------------------------
// series_engine: saturating fixed-point power-series evaluator, sum s_k*c_k*x^(k+1).
// Optional early exit on small terms via macro SERIES_EARLY_EXIT_EN.    Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module series_engine #(
    parameter int WIDTH   = 16,
    parameter int FRAC    = 14,
    parameter int N_TERMS = 8,
    parameter int THRESH  = 1024
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    series_engine_if.slave sif
);
    localparam int CW = $clog2(N_TERMS);
    localparam logic signed [WIDTH-1:0]   MAXV = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0]   MINV = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic signed [2*WIDTH-1:0] PMAX = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [2*WIDTH-1:0] PMIN = {{(WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    if (N_TERMS < 2 || THRESH < 0) begin : g_param_check
        $error("series_engine: N_TERMS must be >= 2 and THRESH >= 0");
    end

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_MULC = 3'd2,
        S_ACC  = 3'd3,
        S_MULX = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t                  state_q, state_d;
    logic signed [WIDTH-1:0] x_q, x_d, p_q, p_d, prod_q, prod_d, acc_q, acc_d;
    logic [CW-1:0]           k_q, k_d;
    logic                    alt_q, alt_d;
    logic [CW:0]             used_q, used_d;
    logic                    w_exit;

    // Floor-shifted fixed-point product, clamped to the WIDTH range.
    function automatic logic signed [WIDTH-1:0] scale(input logic signed [WIDTH-1:0] a,
                                                      input logic signed [WIDTH-1:0] b);
        logic signed [2*WIDTH-1:0] full;
        logic signed [2*WIDTH-1:0] sh;
        full = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
        sh   = full >>> FRAC;
        if (sh > PMAX) return MAXV;
        if (sh < PMIN) return MINV;
        return sh[WIDTH-1:0];
    endfunction

    function automatic logic signed [WIDTH-1:0] sat_acc(input logic signed [WIDTH-1:0] a,
                                                        input logic signed [WIDTH-1:0] b,
                                                        input logic                    sub);
        logic signed [WIDTH:0] ae, be, s;
        ae = {a[WIDTH-1], a};
        be = {b[WIDTH-1], b};
        s  = sub ? (ae - be) : (ae + be);
        if (s[WIDTH] != s[WIDTH-1]) return s[WIDTH] ? MINV : MAXV;
        return s[WIDTH-1:0];
    endfunction

`ifdef SERIES_EARLY_EXIT_EN
    logic signed [WIDTH-1:0] w_mag;
    // The most-negative product has no positive twin; treat it as full scale.
    always_comb w_mag = (prod_q == MINV) ? MAXV : (prod_q[WIDTH-1] ? -prod_q : prod_q);
    assign w_exit = (int'(w_mag) < THRESH);
`else
    assign w_exit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            p_q     <= '0;
            prod_q  <= '0;
            acc_q   <= '0;
            k_q     <= '0;
            alt_q   <= 1'b0;
            used_q  <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            p_q     <= p_d;
            prod_q  <= prod_d;
            acc_q   <= acc_d;
            k_q     <= k_d;
            alt_q   <= alt_d;
            used_q  <= used_d;
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        p_d     = p_q;
        prod_d  = prod_q;
        acc_d   = acc_q;
        k_d     = k_q;
        alt_d   = alt_q;
        used_d  = used_q;
        case (state_q)
            S_IDLE: if (sif.start) state_d = S_LOAD;
            S_LOAD: begin
                x_d     = sif.x_in;
                p_d     = sif.x_in;
                acc_d   = '0;
                k_d     = '0;
                alt_d   = sif.alt_sign;
                state_d = S_MULC;
            end
            S_MULC: begin
                prod_d  = scale(p_q, sif.coef_data);
                state_d = S_ACC;
            end
            S_ACC: begin
                acc_d  = sat_acc(acc_q, prod_q, alt_q & k_q[0]);
                used_d = {1'b0, k_q} + {{CW{1'b0}}, 1'b1};
                if (k_q == CW'(N_TERMS - 1) || w_exit) begin
                    state_d = S_DONE;
                end else begin
                    k_d     = k_q + 1'b1;
                    state_d = S_MULX;
                end
            end
            S_MULX: begin
                p_d     = scale(p_q, x_q);
                state_d = S_MULC;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign sif.busy       = (state_q == S_LOAD) || (state_q == S_MULC) ||
                            (state_q == S_ACC)  || (state_q == S_MULX);
    assign sif.done       = (state_q == S_DONE);
    assign sif.result     = acc_q;
    assign sif.coef_addr  = k_q;
    assign sif.terms_used = used_q;
endmodule

`default_nettype wire
